instr_fetch_unit: RTL and testbench

// - Instruction-side client of the shared-memory selector: owns the fetch PC, issues reads on the

---
 rtl/cpu_pkg.sv | 24 ++
 rtl/fetch_fifo.sv | 68 ++++++
 rtl/instr_fetch_unit.sv | 68 ++++++
 tb/tb_instr_fetch_unit.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU-side definitions: default fetch geometry and the prefetch entry layout.
package cpu_pkg;

    localparam int ADDR_W     = 8;
    localparam int DATA_W     = 32;
    localparam int FIFO_DEPTH = 2;
    localparam logic [ADDR_W-1:0] RESET_PC = '0;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] instr;
    } fetch_entry_t;

    localparam int ENTRY_W = $bits(fetch_entry_t);

    function automatic fetch_entry_t make_entry(input logic [ADDR_W-1:0] pc,
                                                input logic [DATA_W-1:0] instr);
        fetch_entry_t e;
        e.pc    = pc;
        e.instr = instr;
        return e;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO holding prefetched {pc, instr} entries; flush beats push and pop.
module fetch_fifo #(
    parameter int WIDTH = 40,
    parameter int DEPTH = 2,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] head_data,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             pop_ok;
    logic             push_ok;

    assign pop_ok  = pop & (count_q != '0);
    assign push_ok = push & ((count_q < CNT_W'(DEPTH)) | pop_ok) & ~flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is not reset; stale entries are unreachable because count gates visibility.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_data;
    end

    assign head_data = mem_q[rd_ptr_q];
    assign count     = count_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: owns the fetch PC, reads during instruction slots, feeds decode.
module instr_fetch_unit
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              slot_instr,
    output logic [ADDR_W-1:0] mem_addr_instr,
    output logic              mem_read_en_instr,
    input  logic [DATA_W-1:0] mem_read_val_instr,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [DATA_W-1:0] instr_word,
    output logic [ADDR_W-1:0] instr_pc
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [CNT_W-1:0]  count;
    fetch_entry_t      head;
    fetch_entry_t      push_entry;
    logic              pop;
    logic              space;
    logic              issue;

    assign pop   = instr_valid & instr_ready;
    assign space = (count < CNT_W'(FIFO_DEPTH)) | pop;
    // Gating with rst_n keeps the request low the instant reset asserts, before any edge.
    assign issue = slot_instr & space & ~redirect_valid & rst_n;

    assign mem_addr_instr    = fetch_pc_q;
    assign mem_read_en_instr = issue;
    assign push_entry        = make_entry(fetch_pc_q, mem_read_val_instr);

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        if (redirect_valid) fetch_pc_d = redirect_pc;
        else if (issue)     fetch_pc_d = fetch_pc_q + ADDR_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) fetch_pc_q <= RESET_PC;
        else        fetch_pc_q <= fetch_pc_d;
    end

    fetch_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fetch_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (issue),
        .push_data (push_entry),
        .pop       (pop),
        .flush     (redirect_valid),
        .head_data (head),
        .count     (count)
    );

    assign instr_valid = (count != '0);
    assign instr_word  = instr_valid ? head.instr : '0;
    assign instr_pc    = instr_valid ? head.pc    : '0;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: streaming, stall, redirect, wrap and mid-stream reset.
module tb_instr_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        slot_instr;
    logic [7:0]  mem_addr_instr;
    logic        mem_read_en_instr;
    logic [31:0] mem_read_val_instr;
    logic        redirect_valid;
    logic [7:0]  redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_word;
    logic [7:0]  instr_pc;

    int checks = 0;
    int errors = 0;

    instr_fetch_unit dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .slot_instr         (slot_instr),
        .mem_addr_instr     (mem_addr_instr),
        .mem_read_en_instr  (mem_read_en_instr),
        .mem_read_val_instr (mem_read_val_instr),
        .redirect_valid     (redirect_valid),
        .redirect_pc        (redirect_pc),
        .instr_valid        (instr_valid),
        .instr_ready        (instr_ready),
        .instr_word         (instr_word),
        .instr_pc           (instr_pc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] word_of(input logic [7:0] a);
        return 32'(a) * 32'h1111_1111;
    endfunction

    // Memory contents: word at address a is a*0x11111111, returned combinationally.
    assign mem_read_val_instr = word_of(mem_addr_instr);

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Apply inputs just after the falling edge, then let combinational outputs settle.
    task automatic cyc(input bit s, input bit r, input bit rv, input logic [7:0] p);
        @(negedge clk);
        slot_instr     = s;
        instr_ready    = r;
        redirect_valid = rv;
        redirect_pc    = p;
        #1;
    endtask

    initial begin
        rst_n          = 1'b0;
        slot_instr     = 1'b0;
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;

        // Reset state, even with a slot presented.
        cyc(1, 1, 0, 8'h00);
        check("rst_read_en", 64'(mem_read_en_instr), 64'd0);
        check("rst_valid",   64'(instr_valid),       64'd0);
        check("rst_word",    64'(instr_word),        64'd0);
        check("rst_pc",      64'(instr_pc),          64'd0);
        check("rst_addr",    64'(mem_addr_instr),    64'd0);
        cyc(0, 1, 0, 8'h00);
        rst_n = 1'b1;
        #1;
        check("rel_read_en", 64'(mem_read_en_instr), 64'd0);

        // Alternating slots, decode always ready: one output per two cycles.
        for (int i = 0; i < 8; i++) begin
            cyc(i % 2 == 0, 1, 0, 8'h00);
            if (i % 2 == 0) begin
                check("str_read_en", 64'(mem_read_en_instr), 64'd1);
                check("str_addr",    64'(mem_addr_instr),    64'(i / 2));
                check("str_valid0",  64'(instr_valid),       64'd0);
            end else begin
                check("str_read_en0", 64'(mem_read_en_instr), 64'd0);
                check("str_valid",    64'(instr_valid),       64'd1);
                check("str_pc",       64'(instr_pc),          64'(i / 2));
                check("str_word",     64'(instr_word),        64'(word_of(8'(i / 2))));
            end
        end

        // Decode stalled for 10 cycles: two fetches fill the FIFO, then no more requests.
        for (int i = 0; i < 10; i++) begin
            cyc(i % 2 == 0, 0, 0, 8'h00);
            check("stall_read_en", 64'(mem_read_en_instr), 64'((i % 2 == 0) && (i < 4)));
            if (i > 0) begin
                check("stall_valid", 64'(instr_valid), 64'd1);
                check("stall_pc",    64'(instr_pc),    64'h04);
                check("stall_word",  64'(instr_word),  64'(word_of(8'h04)));
            end
        end

        // Release: first cycle is a slot on a full FIFO with a pop, so a read still issues.
        for (int i = 0; i < 4; i++) begin
            cyc(i % 2 == 0, 1, 0, 8'h00);
            check("rel_valid", 64'(instr_valid), 64'd1);
            check("rel_pc",    64'(instr_pc),    64'(4 + i));
            check("rel_word",  64'(instr_word),  64'(word_of(8'(4 + i))));
            if (i == 0) begin
                check("fullpop_read_en", 64'(mem_read_en_instr), 64'd1);
                check("fullpop_addr",    64'(mem_addr_instr),    64'h06);
            end
            if (i == 2) begin
                check("rel_read_en", 64'(mem_read_en_instr), 64'd1);
                check("rel_addr",    64'(mem_addr_instr),    64'h07);
            end
        end

        // Refill to full: entries 8 and 9.
        cyc(1, 0, 0, 8'h00);
        check("fill_addr8", 64'(mem_addr_instr), 64'h08);
        cyc(0, 0, 0, 8'h00);
        cyc(1, 0, 0, 8'h00);
        check("fill_addr9", 64'(mem_addr_instr), 64'h09);

        // Redirect in a slot while full and ready: no read, head not consumed, FIFO flushed.
        cyc(1, 1, 1, 8'h40);
        check("redir_read_en", 64'(mem_read_en_instr), 64'd0);
        check("redir_head_pc", 64'(instr_pc),          64'h08);
        cyc(0, 0, 0, 8'h00);
        check("redir_flushed", 64'(instr_valid),       64'd0);
        cyc(1, 0, 0, 8'h00);
        check("redir_read_en1", 64'(mem_read_en_instr), 64'd1);
        check("redir_addr",     64'(mem_addr_instr),    64'h40);
        cyc(0, 1, 0, 8'h00);
        check("redir_out_valid", 64'(instr_valid), 64'd1);
        check("redir_out_pc",    64'(instr_pc),    64'h40);
        check("redir_out_word",  64'(instr_word),  64'(word_of(8'h40)));

        // PC wrap: 0xFF then 0x00.
        cyc(0, 1, 1, 8'hFF);
        check("wrap_empty", 64'(instr_valid), 64'd0);
        cyc(1, 1, 0, 8'h00);
        check("wrap_addr_ff", 64'(mem_addr_instr), 64'hFF);
        cyc(0, 1, 0, 8'h00);
        check("wrap_pc_ff",   64'(instr_pc),   64'hFF);
        check("wrap_word_ff", 64'(instr_word), 64'h0000_0000_FFFF_FFEF);
        cyc(1, 1, 0, 8'h00);
        check("wrap_read_en", 64'(mem_read_en_instr), 64'd1);
        check("wrap_addr_00", 64'(mem_addr_instr),    64'h00);
        cyc(0, 1, 0, 8'h00);
        check("wrap_valid_00", 64'(instr_valid), 64'd1);
        check("wrap_pc_00",    64'(instr_pc),    64'h00);

        // Mid-stream reset: fill with entries 1 and 2, then assert reset between edges.
        cyc(1, 0, 0, 8'h00);
        check("mid_addr1", 64'(mem_addr_instr), 64'h01);
        cyc(0, 0, 0, 8'h00);
        cyc(1, 0, 0, 8'h00);
        cyc(0, 0, 0, 8'h00);
        check("mid_head_pc", 64'(instr_pc), 64'h01);
        #2;
        rst_n      = 1'b0;
        slot_instr = 1'b1;
        #1;
        check("mid_rst_valid",   64'(instr_valid),       64'd0);
        check("mid_rst_word",    64'(instr_word),        64'd0);
        check("mid_rst_pc",      64'(instr_pc),          64'd0);
        check("mid_rst_read_en", 64'(mem_read_en_instr), 64'd0);
        check("mid_rst_addr",    64'(mem_addr_instr),    64'd0);
        cyc(1, 0, 0, 8'h00);
        rst_n = 1'b1;
        #1;
        check("post_rst_read_en", 64'(mem_read_en_instr), 64'd1);
        check("post_rst_addr",    64'(mem_addr_instr),    64'h00);
        cyc(0, 0, 0, 8'h00);
        check("post_rst_valid", 64'(instr_valid), 64'd1);
        check("post_rst_pc",    64'(instr_pc),    64'h00);
        cyc(1, 0, 0, 8'h00);
        check("post_rst_addr1", 64'(mem_addr_instr), 64'h01);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
